// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit common-anode seven-segment driver with dead time, blink,
// blanking, decimal points, leading-zero suppression and frame-aligned updates.
module seg7_scan_driver #(
  parameter int DIGIT_TICKS = 5000,
  parameter int DEAD_TICKS  = 250,
  parameter int BLINK_TICKS = 1250000
) (
  input  logic        fiveMhz,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic [7:0]  blink,
  input  logic        lzs_en,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start,
  output logic        blink_phase
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_DEAD  = TW'(DEAD_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [TW-1:0] tickCount;
  logic [2:0]    digitIndex;
  logic [BW-1:0] blinkCount;

  logic [31:0] pendDigits, shDigits;
  logic [7:0]  pendDp, pendBlank, pendBlink;
  logic [7:0]  shDp, shBlank, shBlink;
  logic        pendLzs, shLzs, pendValid;

  logic [7:0] zeroFrom;
  logic [7:0] digitDark;
  logic [3:0] curNib;
  logic       frameEnd;

  function automatic logic [6:0] encode(input logic [3:0] n);
    case (n)
      4'h0: encode = 7'h40;
      4'h1: encode = 7'h79;
      4'h2: encode = 7'h24;
      4'h3: encode = 7'h30;
      4'h4: encode = 7'h19;
      4'h5: encode = 7'h12;
      4'h6: encode = 7'h02;
      4'h7: encode = 7'h78;
      4'h8: encode = 7'h00;
      4'h9: encode = 7'h10;
      4'hA: encode = 7'h08;
      4'hB: encode = 7'h03;
      4'hC: encode = 7'h46;
      4'hD: encode = 7'h21;
      4'hE: encode = 7'h06;
      default: encode = 7'h0E;
    endcase
  endfunction

  // Digit k is a leading zero when it and every digit to its left are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dark
      assign zeroFrom[gi] = ~|shDigits[31:4*gi];
      if (gi == 0) begin : g_lsd
        assign digitDark[gi] = shBlank[gi] | (shBlink[gi] & blink_phase);
      end else begin : g_upper
        assign digitDark[gi] = shBlank[gi] | (shBlink[gi] & blink_phase) |
                               (shLzs & zeroFrom[gi]);
      end
    end
  endgenerate

  assign curNib   = shDigits[4*digitIndex +: 4];
  assign frameEnd = (tickCount == TICK_LAST) && (digitIndex == 3'd7);

  always_ff @(posedge fiveMhz) begin
    if (reset) begin
      tickCount   <= '0;
      digitIndex  <= '0;
      blinkCount  <= '0;
      blink_phase <= 1'b0;
      seg         <= 8'hFF;
      an          <= 8'hFF;
      frame_start <= 1'b0;
      pendValid   <= 1'b0;
      pendDigits  <= '0;
      pendDp      <= '0;
      pendBlank   <= 8'hFF;
      pendBlink   <= '0;
      pendLzs     <= 1'b0;
      shDigits    <= '0;
      shDp        <= '0;
      shBlank     <= 8'hFF;
      shBlink     <= '0;
      shLzs       <= 1'b0;
    end else begin
      if (tickCount == TICK_LAST) begin
        tickCount  <= '0;
        digitIndex <= 3'(digitIndex + 3'd1);
      end else begin
        tickCount <= TW'(tickCount + TW'(1));
      end

      if (blinkCount == BLINK_LAST) begin
        blinkCount  <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blinkCount <= BW'(blinkCount + BW'(1));
      end

      frame_start <= (tickCount == '0) && (digitIndex == 3'd0);

      // Anode stays asserted for dark digits so every slot has the same duty.
      if (tickCount < TICK_DEAD) begin
        an  <= 8'hFF;
        seg <= 8'hFF;
      end else begin
        an  <= ~(8'b1 << digitIndex);
        seg <= digitDark[digitIndex] ? 8'hFF : {~shDp[digitIndex], encode(curNib)};
      end

      // A load on the boundary edge lands in pending and waits a full frame.
      if (load) begin
        pendDigits <= digits;
        pendDp     <= dp;
        pendBlank  <= blank;
        pendBlink  <= blink;
        pendLzs    <= lzs_en;
        pendValid  <= 1'b1;
      end else if (frameEnd) begin
        pendValid <= 1'b0;
      end

      if (frameEnd && pendValid) begin
        shDigits <= pendDigits;
        shDp     <= pendDp;
        shBlank  <= pendBlank;
        shBlink  <= pendBlink;
        shLzs    <= pendLzs;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues hand-computed per-slot {an,seg} values,
// a monitor pops one entry at the start of each driven slot and checks it.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] digits;
  logic [7:0]  dp, blank, blink;
  logic        lzs_en, load;
  logic [7:0]  seg, an;
  logic        frame_start, blink_phase;

  seg7_scan_driver #(.DIGIT_TICKS(4), .DEAD_TICKS(1), .BLINK_TICKS(16)) dut (
    .fiveMhz(clk), .reset(reset), .digits(digits), .dp(dp), .blank(blank),
    .blink(blink), .lzs_en(lzs_en), .load(load), .seg(seg), .an(an),
    .frame_start(frame_start), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int lastFs = 0;
  bit havePrev = 0;
  logic [15:0] expQ[$];

  localparam logic [63:0] DARK     = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] T_COUNT  = 64'hF9A4B099_9282F880;
  localparam logic [63:0] T_LZS    = 64'hFFFFFFFF_FFF9C092;
  localparam logic [63:0] T_BLINK  = 64'hFF86A1C6_83089080;
  localparam logic [63:0] T_B      = 64'hF88292FF_B0A4F9C0;
  localparam logic [63:0] T_C      = 64'h80908883_C6A1868E;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%h t=%0t", name, act, $time);
    end
  endtask

  task automatic pushFrame(input logic [63:0] segs, input int n);
    logic [7:0] anv;
    for (int k = 0; k < n; k++) begin
      anv = ~(8'b1 << k);
      expQ.push_back({anv, segs[8*k +: 8]});
    end
  endtask

  task automatic waitFrame(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    check({name, " frame_start"}, {31'd0, frame_start}, 32'd1);
    if (havePrev) check({name, " frame period"}, cycleCnt - lastFs, 32'd32);
    lastFs = cycleCnt;
    havePrev = 1;
    check({name, " blink_phase at frame start"}, {31'd0, blink_phase}, 32'd0);
  endtask

  task automatic doLoad(input logic [31:0] d, input logic [7:0] dpv, input logic [7:0] bl,
                        input logic [7:0] bk, input logic lz);
    digits = d; dp = dpv; blank = bl; blink = bk; lzs_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Monitor: dead cycles must be dark; each driven slot pops one expectation.
  logic [7:0]  prevAn = 8'hFF;
  logic [15:0] held;
  bit          haveExp = 0;
  always @(negedge clk) begin
    if (^{an, seg} !== 1'bx) begin
      if (an === 8'hFF) begin
        if (seg !== 8'hFF) check("dead seg", {24'd0, seg}, 32'hFF);
      end else begin
        if (prevAn === 8'hFF) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            haveExp = 0;
            $display("FAIL unexpected slot actual an=%h seg=%h required=none", an, seg);
          end else begin
            held = expQ.pop_front();
            haveExp = 1;
          end
        end
        if (haveExp) check("slot {an,seg}", {16'd0, an, seg}, {16'd0, held});
      end
      prevAn = an;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; digits = '0; dp = '0; blank = '0; blink = '0; lzs_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset an", {24'd0, an}, 32'hFF);
    check("reset seg", {24'd0, seg}, 32'hFF);
    check("reset frame_start", {31'd0, frame_start}, 32'd0);
    check("reset blink_phase", {31'd0, blink_phase}, 32'd0);
    reset = 1'b0;

    waitFrame("F0");
    pushFrame(DARK, 8);
    repeat (16) @(negedge clk);
    check("F0 blink_phase half period", {31'd0, blink_phase}, 32'd1);

    waitFrame("F1");
    pushFrame(DARK, 8);
    doLoad(32'h12345678, 8'h00, 8'h00, 8'h00, 1'b0);

    waitFrame("F2");
    pushFrame(T_COUNT, 8);
    doLoad(32'h00000105, 8'h00, 8'h00, 8'h00, 1'b1);

    waitFrame("F3");
    pushFrame(T_LZS, 8);
    doLoad(32'hFEDCBA98, 8'h04, 8'h00, 8'h83, 1'b0);

    waitFrame("F4");
    pushFrame(T_BLINK, 8);
    doLoad(32'h11111111, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    doLoad(32'h76543210, 8'h00, 8'h10, 8'h00, 1'b0);

    waitFrame("F5");
    pushFrame(T_B, 8);
    repeat (30) @(negedge clk);
    doLoad(32'h89ABCDEF, 8'h00, 8'h00, 8'h00, 1'b0);

    waitFrame("F6");
    pushFrame(T_B, 8);

    waitFrame("F7");
    pushFrame(T_C, 8);

    waitFrame("F8");
    pushFrame(T_C, 6);
    doLoad(32'h55555555, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset an", {24'd0, an}, 32'hFF);
    check("mid reset seg", {24'd0, seg}, 32'hFF);
    check("mid reset blink_phase", {31'd0, blink_phase}, 32'd0);
    check("mid reset frame_start", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    havePrev = 0;

    waitFrame("F9");
    pushFrame(DARK, 8);
    repeat (16) @(negedge clk);
    check("F9 blink_phase half period", {31'd0, blink_phase}, 32'd1);

    waitFrame("F10");
    pushFrame(DARK, 8);

    waitFrame("F11");
    check("scoreboard drained", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
